// File: rtl/fetch_pkg.sv
// Shared types and default constants for the fetch stage.
// Imported by the fetch unit, its IF/ID register and anything that binds to them.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  localparam int          FETCH_PC_WIDTH    = 18;
  localparam int          FETCH_INSTR_WIDTH = 32;
  localparam logic [31:0] FETCH_HALT_INSTR  = 32'hFFFF_FFFF;
  localparam logic [31:0] FETCH_NOP_INSTR   = 32'h0000_0000;

endpackage

// File: rtl/fetch_if.sv
// Fetch-to-decode channel: the IF/ID register contents plus decode's ready.
// Handshake: a transfer happens on every rising edge where id_valid && id_ready;
// while id_valid is high and id_ready is low, id_instr/id_pc/id_pc_next hold steady.
interface fetch_if #(
  parameter int PC_WIDTH          = 18,
  parameter int INSTRUCTION_WIDTH = 32
);

  logic                         id_valid;
  logic                         id_ready;
  logic [INSTRUCTION_WIDTH-1:0] id_instr;
  logic [PC_WIDTH-1:0]          id_pc;
  logic [PC_WIDTH-1:0]          id_pc_next;

  modport master (
    output id_valid,
    output id_instr,
    output id_pc,
    output id_pc_next,
    input  id_ready
  );

  modport slave (
    input  id_valid,
    input  id_instr,
    input  id_pc,
    input  id_pc_next,
    output id_ready
  );

endinterface

// File: rtl/if_id_register.sv
// IF/ID pipeline register: loads a fetched word with its address, clears to an
// empty NOP slot, or holds. Clear takes priority over load.
module if_id_register #(
  parameter int                           PC_WIDTH          = 18,
  parameter int                           INSTRUCTION_WIDTH = 32,
  parameter logic [INSTRUCTION_WIDTH-1:0] NOP_INSTR         = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         load,
  input  logic                         clear,
  input  logic [INSTRUCTION_WIDTH-1:0] load_instr,
  input  logic [PC_WIDTH-1:0]          load_pc,
  output logic                         valid,
  output logic [INSTRUCTION_WIDTH-1:0] instr,
  output logic [PC_WIDTH-1:0]          pc,
  output logic [PC_WIDTH-1:0]          pc_next
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid   <= 1'b0;
      instr   <= NOP_INSTR;
      pc      <= '0;
      pc_next <= PC_WIDTH'(1);
    end else if (clear) begin
      // pc/pc_next keep their last value; only valid and instr mark the slot empty
      valid <= 1'b0;
      instr <= NOP_INSTR;
    end else if (load) begin
      valid   <= 1'b1;
      instr   <= load_instr;
      pc      <= load_pc;
      pc_next <= load_pc + PC_WIDTH'(1);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage controller: owns the PC, reads the combinational instruction memory,
// feeds the IF/ID register, and handles redirects, HALT detection and fetch counting.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                           PC_WIDTH          = FETCH_PC_WIDTH,
  parameter int                           INSTRUCTION_WIDTH = FETCH_INSTR_WIDTH,
  parameter logic [PC_WIDTH-1:0]          RESET_PC          = '0,
  parameter logic [INSTRUCTION_WIDTH-1:0] HALT_INSTR        = FETCH_HALT_INSTR,
  parameter logic [INSTRUCTION_WIDTH-1:0] NOP_INSTR         = FETCH_NOP_INSTR
) (
  input  logic                         clk,
  input  logic                         rst_n,
  output logic [PC_WIDTH-1:0]          imem_pc,
  input  logic [INSTRUCTION_WIDTH-1:0] imem_instr,
  input  logic                         redirect_valid,
  input  logic [PC_WIDTH-1:0]          redirect_pc,
  fetch_if.master                      dec,
  output logic                         halted,
  output logic [31:0]                  fetch_count,
  output fetch_state_t                 state_dbg
);

  fetch_state_t                 state;
  logic [PC_WIDTH-1:0]          pc_q;
  logic                         fire;
  logic                         drain;
  logic                         is_halt;
  logic                         reg_valid;
  logic [INSTRUCTION_WIDTH-1:0] reg_instr;
  logic [PC_WIDTH-1:0]          reg_pc;
  logic [PC_WIDTH-1:0]          reg_pc_next;

  assign is_halt = (imem_instr == HALT_INSTR);
  assign fire    = (state == RUN) && !redirect_valid && (!reg_valid || dec.id_ready);
  assign drain   = !fire && reg_valid && dec.id_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BOOT;
      pc_q        <= RESET_PC;
      halted      <= 1'b0;
      fetch_count <= '0;
    end else if (redirect_valid) begin
      // A redirect from any state, BOOT included, lands in RUN at the new target
      state  <= RUN;
      pc_q   <= redirect_pc;
      halted <= 1'b0;
    end else begin
      case (state)
        BOOT: state <= RUN;
        RUN: begin
          if (fire) begin
            fetch_count <= fetch_count + 32'd1;
            if (is_halt) begin
              state  <= HALT;
              halted <= 1'b1;
            end else begin
              pc_q <= pc_q + PC_WIDTH'(1);
            end
          end
        end
        HALT:    state <= HALT;
        default: state <= BOOT;
      endcase
    end
  end

  if_id_register #(
    .PC_WIDTH          (PC_WIDTH),
    .INSTRUCTION_WIDTH (INSTRUCTION_WIDTH),
    .NOP_INSTR         (NOP_INSTR)
  ) u_if_id (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (fire),
    .clear      (redirect_valid || drain),
    .load_instr (imem_instr),
    .load_pc    (pc_q),
    .valid      (reg_valid),
    .instr      (reg_instr),
    .pc         (reg_pc),
    .pc_next    (reg_pc_next)
  );

  assign imem_pc        = pc_q;
  assign state_dbg      = state;
  assign dec.id_valid   = reg_valid;
  assign dec.id_instr   = reg_instr;
  assign dec.id_pc      = reg_pc;
  assign dec.id_pc_next = reg_pc_next;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a cycle-level model of the fetch rules checked every cycle,
// plus hand-computed checkpoints, and a second instance with RESET_PC at the top of the PC range.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam logic [31:0] HALT_W = 32'hFFFF_FFFF;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // DUT 1: RESET_PC = 0
  logic [31:0]  imem [0:1023];
  logic [17:0]  imem_pc1;
  logic [31:0]  imem_instr1;
  logic         redir1 = 1'b0;
  logic [17:0]  redir_pc1 = '0;
  logic         halted1;
  logic [31:0]  count1;
  fetch_state_t state1;
  fetch_if #(.PC_WIDTH(18), .INSTRUCTION_WIDTH(32)) dec1 ();

  assign imem_instr1 = imem[imem_pc1[9:0]];

  fetch_unit #(.PC_WIDTH(18), .INSTRUCTION_WIDTH(32), .RESET_PC(18'h0)) dut1 (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_pc        (imem_pc1),
    .imem_instr     (imem_instr1),
    .redirect_valid (redir1),
    .redirect_pc    (redir_pc1),
    .dec            (dec1.master),
    .halted         (halted1),
    .fetch_count    (count1),
    .state_dbg      (state1)
  );

  // DUT 2: RESET_PC at the wrap boundary
  logic [31:0]  imem2 [0:1023];
  logic [17:0]  imem_pc2;
  logic [31:0]  imem_instr2;
  logic         redir2 = 1'b0;
  logic [17:0]  redir_pc2 = '0;
  logic         halted2;
  logic [31:0]  count2;
  fetch_state_t state2;
  fetch_if #(.PC_WIDTH(18), .INSTRUCTION_WIDTH(32)) dec2 ();

  assign imem_instr2 = imem2[imem_pc2[9:0]];

  fetch_unit #(.PC_WIDTH(18), .INSTRUCTION_WIDTH(32), .RESET_PC(18'h3FFFF)) dut2 (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_pc        (imem_pc2),
    .imem_instr     (imem_instr2),
    .redirect_valid (redir2),
    .redirect_pc    (redir_pc2),
    .dec            (dec2.master),
    .halted         (halted2),
    .fetch_count    (count2),
    .state_dbg      (state2)
  );

  // behavioural model of DUT 1: fetch address, one-entry decode slot, counters
  logic [17:0] m_fpc;
  logic        m_booting, m_stopped;
  logic        m_valid;
  logic [31:0] m_instr;
  logic [17:0] m_pc, m_pcn;
  logic [31:0] m_count;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_fpc = 18'h0; m_booting = 1'b1; m_stopped = 1'b0;
      m_valid = 1'b0; m_instr = 32'h0; m_pc = 18'h0; m_pcn = 18'h1; m_count = 0;
    end else if (redir1) begin
      m_fpc = redir_pc1; m_booting = 1'b0; m_stopped = 1'b0;
      m_valid = 1'b0; m_instr = 32'h0;
    end else if (m_booting) begin
      m_booting = 1'b0;
    end else if (!m_stopped && (!m_valid || dec1.id_ready)) begin
      m_instr = imem[m_fpc[9:0]];
      m_valid = 1'b1;
      m_pc = m_fpc;
      m_pcn = m_fpc + 18'd1;
      m_count = m_count + 1;
      if (m_instr == HALT_W) m_stopped = 1'b1;
      else m_fpc = m_fpc + 18'd1;
    end else if (m_valid && dec1.id_ready) begin
      m_valid = 1'b0;
      m_instr = 32'h0;
    end
  end

  // scoreboard helper
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // per-cycle compare against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("m_id_valid", 64'(dec1.id_valid), 64'(m_valid));
      check("m_id_instr", 64'(dec1.id_instr), 64'(m_instr));
      check("m_halted", 64'(halted1), 64'(m_stopped));
      check("m_imem_pc", 64'(imem_pc1), 64'(m_fpc));
      check("m_fetch_count", 64'(count1), 64'(m_count));
      if (m_valid) begin
        check("m_id_pc", 64'(dec1.id_pc), 64'(m_pc));
        check("m_id_pc_next", 64'(dec1.id_pc_next), 64'(m_pcn));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [19:0] ready_pat;

  initial begin
    for (int i = 0; i < 1024; i++) begin
      imem[i]  = 32'(i + 100);
      imem2[i] = 32'(i + 5000);
    end
    dec1.id_ready = 1'b1;
    dec2.id_ready = 1'b1;
    step(2);

    // reset values
    check("rst_id_valid", 64'(dec1.id_valid), 64'h0);
    check("rst_id_instr", 64'(dec1.id_instr), 64'h0);
    check("rst_id_pc", 64'(dec1.id_pc), 64'h0);
    check("rst_id_pc_next", 64'(dec1.id_pc_next), 64'h1);
    check("rst_halted", 64'(halted1), 64'h0);
    check("rst_count", 64'(count1), 64'h0);
    check("rst_imem_pc", 64'(imem_pc1), 64'h0);
    check("rst_state", 64'(state1), 64'(BOOT));
    check("rst_imem_pc2", 64'(imem_pc2), 64'h3FFFF);
    chk_en = 1'b1;
    rst_n = 1'b1;

    // boot cycle, then sequential fetch
    step(1);
    check("boot_valid", 64'(dec1.id_valid), 64'h0);
    check("boot_state", 64'(state1), 64'(RUN));
    step(1);
    check("seq0_instr", 64'(dec1.id_instr), 64'd100);
    check("seq0_pc", 64'(dec1.id_pc), 64'd0);
    check("wrap_pc2", 64'(dec2.id_pc), 64'h3FFFF);
    check("wrap_pc_next2", 64'(dec2.id_pc_next), 64'h0);
    check("wrap_instr2", 64'(dec2.id_instr), 64'd6023);
    step(1);
    check("seq1_instr", 64'(dec1.id_instr), 64'd101);
    check("seq1_pc", 64'(dec1.id_pc), 64'd1);
    check("wrap_next_pc2", 64'(dec2.id_pc), 64'h0);
    check("wrap_next_instr2", 64'(dec2.id_instr), 64'd5000);
    step(1);
    check("seq2_instr", 64'(dec1.id_instr), 64'd102);
    check("seq2_pc", 64'(dec1.id_pc), 64'd2);
    check("seq2_count", 64'(count1), 64'd3);

    // stall for 4 cycles with id_pc = 5
    step(3);
    check("pre_stall_pc", 64'(dec1.id_pc), 64'd5);
    dec1.id_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1);
      check("stall_pc", 64'(dec1.id_pc), 64'd5);
      check("stall_imem_pc", 64'(imem_pc1), 64'd6);
      check("stall_count", 64'(count1), 64'd6);
    end
    dec1.id_ready = 1'b1;
    step(1);
    check("release_pc", 64'(dec1.id_pc), 64'd6);
    check("release_count", 64'(count1), 64'd7);

    // redirect with a valid instruction in flight
    redir1 = 1'b1;
    redir_pc1 = 18'h200;
    step(1);
    redir1 = 1'b0;
    check("redir_valid", 64'(dec1.id_valid), 64'h0);
    check("redir_imem_pc", 64'(imem_pc1), 64'h200);
    check("redir_count", 64'(count1), 64'd7);
    step(1);
    check("redir_pc", 64'(dec1.id_pc), 64'h200);
    check("redir_instr", 64'(dec1.id_instr), 64'd612);

    // HALT at address 3
    imem[3] = HALT_W;
    redir1 = 1'b1;
    redir_pc1 = 18'h0;
    step(1);
    redir1 = 1'b0;
    step(4);
    check("halt_instr", 64'(dec1.id_instr), 64'hFFFF_FFFF);
    check("halt_pc", 64'(dec1.id_pc), 64'd3);
    check("halt_flag", 64'(halted1), 64'h1);
    check("halt_imem_pc", 64'(imem_pc1), 64'd3);
    check("halt_count", 64'(count1), 64'd12);
    step(2);
    check("halt_drained", 64'(dec1.id_valid), 64'h0);
    check("halt_hold_count", 64'(count1), 64'd12);
    check("halt_hold_pc", 64'(imem_pc1), 64'd3);

    // resume from HALT
    redir1 = 1'b1;
    redir_pc1 = 18'h10;
    step(1);
    redir1 = 1'b0;
    check("resume_halted", 64'(halted1), 64'h0);
    check("resume_imem_pc", 64'(imem_pc1), 64'h10);
    step(1);
    check("resume_pc", 64'(dec1.id_pc), 64'h10);
    check("resume_instr", 64'(dec1.id_instr), 64'd116);
    check("resume_count", 64'(count1), 64'd13);

    // async reset in the middle of a stall
    dec1.id_ready = 1'b0;
    step(2);
    #2 rst_n = 1'b0;
    #1;
    check("areset_valid", 64'(dec1.id_valid), 64'h0);
    check("areset_instr", 64'(dec1.id_instr), 64'h0);
    check("areset_pc", 64'(dec1.id_pc), 64'h0);
    check("areset_count", 64'(count1), 64'h0);
    check("areset_imem_pc", 64'(imem_pc1), 64'h0);
    check("areset_imem_pc2", 64'(imem_pc2), 64'h3FFFF);
    step(2);
    rst_n = 1'b1;

    // directed ready pattern with a mid-run redirect; the model checks every cycle
    ready_pat = 20'b1011_0011_1010_0111_0110;
    for (int i = 0; i < 20; i++) begin
      dec1.id_ready = ready_pat[i];
      redir1 = (i == 12);
      redir_pc1 = 18'h3FE;
      step(1);
    end
    redir1 = 1'b0;
    dec1.id_ready = 1'b1;
    step(4);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
